// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle fetch/decode/execute/write-back sequencer that
// drives a 16-bit ALU and register file. Each instruction takes FETCH, DECODE,
// EXEC and WB in turn, with no overlap. The PSR lives here, and conditional
// branches are resolved against it.
module alu_issue_ctrl #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    // instruction fetch port
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    // register-file read addresses
    output logic [3:0]      rf_raddr_a,
    output logic [3:0]      rf_raddr_b,
    // ALU controls and results
    output logic [3:0]      alu_op,
    output logic [7:0]      alu_imm,
    output logic            alu_imm_en,
    output logic            alu_carry_in,
    input  logic [15:0]     alu_result,
    input  logic [4:0]      alu_flags,
    // register-file write port
    output logic            rf_we,
    output logic [3:0]      rf_waddr,
    output logic [15:0]     rf_wdata,
    // status
    output logic [4:0]      psr,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // PSR bit positions: {C,L,F,Z,N}
    localparam int P_C = 4;
    localparam int P_L = 3;
    localparam int P_Z = 1;
    localparam int P_N = 0;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [4:0]        psr_q, psr_d;
    logic [15:0]       wb_data_q, wb_data_d;
    logic [4:0]        flag_hold_q, flag_hold_d;
    logic              taken_q, taken_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic              imm_en_q, imm_en_d;
    logic              wr_en_q, wr_en_d;
    logic              psr_upd_q, psr_upd_d;
    logic              bcond_q, bcond_d;
    logic              req_q, req_d;

    // Decode fields from the instruction register
    logic [3:0]        opc, ext;
    logic              dec_legal, dec_nop, dec_cmp, dec_bcond, cond_true;
    logic [3:0]        dec_op;
    logic [PC_W-1:0]   br_off;

    assign opc    = ir_q[15:12];
    assign ext    = ir_q[7:4];
    // Branch displacement is a signed word offset from the incremented PC
    assign br_off = {{(PC_W-8){ir_q[7]}}, ir_q[7:0]};

    // Instruction classification and legality check
    always_comb begin
        dec_legal = 1'b0;
        case (opc)
            4'h0: begin
                case (ext)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                    4'h9, 4'hA, 4'hB, 4'hD: dec_legal = 1'b1;
                    default:                dec_legal = 1'b0;
                endcase
            end
            4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7,
            4'h9, 4'hA, 4'hB, 4'hD, 4'hF: dec_legal = 1'b1;
            4'h8:    dec_legal = ~ir_q[7];  // shift group: IR[7:5] in 000..011
            4'hC:    dec_legal = 1'b1;
            default: dec_legal = 1'b0;
        endcase
        dec_op    = (opc == 4'h0) ? ext : opc;
        dec_nop   = (opc == 4'h0) && (ext == 4'h0);
        dec_cmp   = ((opc == 4'h0) && (ext == 4'hB)) || (opc == 4'hB);
        dec_bcond = (opc == 4'hC);
    end

    // Branch condition evaluated against the PSR as it stands in EXEC
    always_comb begin
        cond_true = 1'b0;
        case (ir_q[11:8])
            4'h0:    cond_true =  psr_q[P_Z];
            4'h1:    cond_true = ~psr_q[P_Z];
            4'h2:    cond_true =  psr_q[P_C];
            4'h3:    cond_true = ~psr_q[P_C];
            4'hA:    cond_true =  psr_q[P_L];
            4'hB:    cond_true = ~psr_q[P_L];
            4'hC:    cond_true =  psr_q[P_N];
            4'hD:    cond_true = ~psr_q[P_N];
            4'hE:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Next-state and datapath register updates for the sequencer
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        psr_d       = psr_q;
        wb_data_d   = wb_data_q;
        flag_hold_d = flag_hold_q;
        taken_d     = taken_q;
        alu_op_d    = alu_op_q;
        imm_en_d    = imm_en_q;
        wr_en_d     = wr_en_q;
        psr_upd_d   = psr_upd_q;
        bcond_d     = bcond_q;
        case (state_q)
            S_FETCH: begin
                // ack only counts while a request is actually outstanding
                if (req_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_op_d  = dec_op;
                imm_en_d  = (opc != 4'h0) && (opc != 4'h8);
                bcond_d   = dec_bcond;
                wr_en_d   = ~(dec_nop | dec_cmp | dec_bcond);
                // MOV and LU leave flags alone; checked on the effective op
                psr_upd_d = ~(dec_nop | dec_bcond | (dec_op == 4'hD) | (dec_op == 4'hF));
                state_d   = dec_legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                wb_data_d   = alu_result;
                flag_hold_d = alu_flags;
                taken_d     = bcond_q & cond_true;
                state_d     = S_WB;
            end
            S_WB: begin
                if (psr_upd_q) psr_d = flag_hold_q;
                if (taken_q)   pc_d  = pc_q + br_off;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        // Request is registered so it stays low through reset and rises on
        // the first clock afterwards
        req_d = (state_d == S_FETCH);
    end

    // State and datapath registers, cleared by asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            psr_q       <= '0;
            wb_data_q   <= '0;
            flag_hold_q <= '0;
            taken_q     <= 1'b0;
            alu_op_q    <= '0;
            imm_en_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            psr_upd_q   <= 1'b0;
            bcond_q     <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            psr_q       <= psr_d;
            wb_data_q   <= wb_data_d;
            flag_hold_q <= flag_hold_d;
            taken_q     <= taken_d;
            alu_op_q    <= alu_op_d;
            imm_en_q    <= imm_en_d;
            wr_en_q     <= wr_en_d;
            psr_upd_q   <= psr_upd_d;
            bcond_q     <= bcond_d;
            req_q       <= req_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign rf_raddr_a   = ir_q[11:8];
    assign rf_raddr_b   = ir_q[3:0];
    assign alu_op       = alu_op_q;
    assign alu_imm      = ir_q[7:0];
    assign alu_imm_en   = imm_en_q;
    assign alu_carry_in = psr_q[P_C];
    assign rf_we        = (state_q == S_WB) && wr_en_q;
    assign rf_waddr     = ir_q[11:8];
    assign rf_wdata     = wb_data_q;
    assign psr          = psr_q;
    assign state        = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a small ALU/register-file model surrounds the
// controller, and expected register writes go through a scoreboard queue.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [3:0]  rf_raddr_a, rf_raddr_b, alu_op, rf_waddr;
    logic [7:0]  alu_imm;
    logic        alu_imm_en, alu_carry_in, rf_we;
    logic [15:0] alu_result, rf_wdata;
    logic [4:0]  alu_flags, psr;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];

    logic [15:0] rf [16];
    logic [3:0]  ex_op;
    logic        ex_imm_en;

    alu_issue_ctrl #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .alu_op(alu_op), .alu_imm(alu_imm), .alu_imm_en(alu_imm_en),
        .alu_carry_in(alu_carry_in),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .psr(psr), .state(state)
    );

    always #5 clk = ~clk;

    // register file model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // reference ALU for the ops the bench uses: ADD, CMP, MOV
    logic [15:0] a_d, a_s;
    logic [16:0] a_sum;
    always_comb begin
        a_d        = rf[rf_raddr_a];
        a_s        = alu_imm_en ? {{8{alu_imm[7]}}, alu_imm} : rf[rf_raddr_b];
        a_sum      = {1'b0, a_d} + {1'b0, a_s};
        alu_result = '0;
        alu_flags  = '0;
        case (alu_op)
            4'h5: begin
                alu_result = a_sum[15:0];
                alu_flags  = {a_sum[16], 1'b0,
                              (a_d[15] == a_s[15]) && (a_sum[15] != a_d[15]),
                              a_sum[15:0] == 16'h0, a_sum[15]};
            end
            4'hB: begin
                alu_result = a_d;
                alu_flags  = {1'b0, a_d < a_s, 1'b0, a_d == a_s,
                              $signed(a_d) < $signed(a_s)};
            end
            4'hD: alu_result = a_s;
            default: ;
        endcase
    end

    // remember decode outputs seen while in EXEC
    always @(negedge clk) begin
        if (state == 3'd2) begin
            ex_op     <= alu_op;
            ex_imm_en <= alu_imm_en;
        end
    end

    // scoreboard: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h, none expected", rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== {e.addr, e.data}) begin
                    errors++;
                    $display("FAIL rf_write: got addr %0d data %h, expected addr %0d data %h",
                             rf_waddr, rf_wdata, e.addr, e.data);
                end
            end
        end
    end

    // Serve one instruction at the next request, return cycles until the
    // controller is back in FETCH (or has halted).
    task automatic fetch(input logic [15:0] inst, output int lat);
        int n = 0;
        while (!imem_req && n < 50) begin @(negedge clk); n++; end
        if (!imem_req) begin
            errors++;
            $display("FAIL fetch_timeout: imem_req never rose for inst %h", inst);
        end
        imem_ack   = 1'b1;
        imem_rdata = inst;
        @(negedge clk);
        imem_ack = 1'b0;
        lat = 1;
        while (state != 3'd0 && state != 3'd4 && lat < 20) begin
            @(negedge clk); lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({state, imem_req, psr, rf_we, rf_waddr, rf_wdata} !== 30'h0) begin
            errors++;
            $display("FAIL reset_state: got state %0d req %b psr %b we %b waddr %0d wdata %h, expected all zero",
                     state, imem_req, psr, rf_we, rf_waddr, rf_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_first_req: got req %b addr %h, expected 1 0000", imem_req, imem_addr);
        end
        // ADD R1,R2 aborted by reset while in DECODE
        imem_ack = 1'b1; imem_rdata = 16'h0152;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL reset_decode: got state %0d expected 1", state);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL reset_async: got state %0d expected 0", state);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (psr !== 5'b00000 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got psr %b req %b expected 00000 0", psr, imem_req);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rerelease: got req %b addr %h expected 1 0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_cmp();
        int lat;
        exp_q.push_back('{4'd1, 16'h0005}); fetch(16'hD105, lat);
        exp_q.push_back('{4'd2, 16'h0007}); fetch(16'hD207, lat);
        checks++;
        if (psr !== 5'b00000) begin
            errors++;
            $display("FAIL movi_psr: got %b expected 00000", psr);
        end
        fetch(16'h01B2, lat);
        checks++;
        if (psr !== 5'b01001) begin
            errors++;
            $display("FAIL cmp_psr: got %b expected 01001", psr);
        end
        checks++;
        if (ex_op !== 4'hB || ex_imm_en !== 1'b0) begin
            errors++;
            $display("FAIL cmp_decode: got op %h imm_en %b expected b 0", ex_op, ex_imm_en);
        end
    endtask

    task automatic test_addi();
        int lat;
        exp_q.push_back('{4'd3, 16'h0001}); fetch(16'hD301, lat);
        exp_q.push_back('{4'd3, 16'h0000}); fetch(16'h53FF, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL addi_latency: got %0d expected 4", lat);
        end
        checks++;
        if (ex_op !== 4'h5 || ex_imm_en !== 1'b1) begin
            errors++;
            $display("FAIL addi_decode: got op %h imm_en %b expected 5 1", ex_op, ex_imm_en);
        end
        checks++;
        if (psr !== 5'b10010) begin
            errors++;
            $display("FAIL addi_psr: got %b expected 10010", psr);
        end
    endtask

    task automatic test_branch();
        int lat;
        for (int i = 0; i < 11; i++) fetch(16'h0000, lat);
        checks++;
        if (imem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL pre_beq_pc: got %h expected 0010", imem_addr);
        end
        fetch(16'hC0FE, lat);
        checks++;
        if (imem_addr !== 16'h000F) begin
            errors++;
            $display("FAIL beq_taken: got %h expected 000f", imem_addr);
        end
        fetch(16'h0000, lat);
        fetch(16'hC1FE, lat);
        checks++;
        if (imem_addr !== 16'h0011) begin
            errors++;
            $display("FAIL bne_not_taken: got %h expected 0011", imem_addr);
        end
        checks++;
        if (psr !== 5'b10010) begin
            errors++;
            $display("FAIL branch_psr: got %b expected 10010", psr);
        end
    endtask

    task automatic test_wait_movi();
        int lat, base;
        logic [15:0] a;
        fetch(16'h0000, base);
        a = imem_addr;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== a) begin
                errors++;
                $display("FAIL wait_hold: got req %b addr %h expected 1 %h", imem_req, imem_addr, a);
            end
            @(negedge clk);
        end
        exp_q.push_back('{4'd4, 16'h0012});
        fetch(16'hD412, lat);
        checks++;
        if (lat + 3 !== 7 || base !== 4) begin
            errors++;
            $display("FAIL wait_latency: got %0d (base %0d) expected 7 (base 4)", lat + 3, base);
        end
        checks++;
        if (rf[4] !== 16'h0012 || psr !== 5'b10010) begin
            errors++;
            $display("FAIL movi_result: got r4 %h psr %b expected 0012 10010", rf[4], psr);
        end
    endtask

    task automatic test_halt();
        int lat;
        logic [15:0] a;
        logic [15:0] ill [3];
        ill[0] = 16'hE000; ill[1] = 16'h8080; ill[2] = 16'h0080;
        for (int k = 0; k < 3; k++) begin
            fetch(ill[k], lat);
            checks++;
            if (state !== 3'd4) begin
                errors++;
                $display("FAIL halt_enter: inst %h got state %0d expected 4", ill[k], state);
            end
            a = imem_addr;
            repeat (4) begin
                @(negedge clk);
                checks++;
                if (state !== 3'd4 || imem_req !== 1'b0 || rf_we !== 1'b0 || imem_addr !== a) begin
                    errors++;
                    $display("FAIL halt_hold: got state %0d req %b we %b addr %h expected 4 0 0 %h",
                             state, imem_req, rf_we, imem_addr, a);
                end
            end
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            checks++;
            if (state !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 16'h0000 || psr !== 5'b0) begin
                errors++;
                $display("FAIL halt_exit: got state %0d req %b addr %h psr %b expected 0 1 0000 00000",
                         state, imem_req, imem_addr, psr);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cmp();
        test_addi();
        test_branch();
        test_wait_movi();
        test_halt();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: got %0d outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
